// File: rtl/i2c_fifo_sched.sv
// -----------------------------------------------------------------------------
// i2c_fifo_sched
//   Sequences the I2C command FIFO. Pops one {addr,data} entry, splits it,
//   hands it to the I2C master byte engine with a start/done handshake and
//   enforces an idle bus gap after every transaction. NACKed entries are
//   dropped (or retried), and a watchdog aborts a master that never answers.
//
//   Optional feature macro: I2C_RETRY_EN
//     defined   : a NACKed entry is re-issued up to MAX_RETRY times (after a
//                 bus gap, without popping) before it is dropped.
//     undefined : any NACK drops the entry; no retry counter exists.
//
// Ports
//   i2c_clock_in    system clock, all logic on posedge
//   i2c_reset_in    synchronous active-high reset
//   enable_in       1 = allowed to start new entries
//   fifo_empty      FIFO empty flag
//   fifo_data_in    FIFO read data, valid one clock after fifo_rd_en_out
//   fifo_rd_en_out  one-cycle pop strobe
//   mst_start_out   one-cycle transaction start to the master
//   mst_addr_out    slave address, held from start until done
//   mst_data_out    write byte, held from start until done
//   mst_done_in     one-cycle completion pulse from the master
//   mst_nack_in     NACK status, only looked at together with mst_done_in
//   busy_out        1 whenever the sequencer is not idle
//   nack_drop_out   one-cycle pulse: entry discarded after its final NACK
//   timeout_out     one-cycle pulse: watchdog abort
//   drop_count_out  saturating count of NACK drops plus timeouts
// -----------------------------------------------------------------------------
module i2c_fifo_sched #(
  parameter int FIFO_WIDTH  = 15,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  i2c_clock_in,
  input  logic                  i2c_reset_in,
  input  logic                  enable_in,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_rd_en_out,
  output logic                  mst_start_out,
  output logic [ADDR_W-1:0]     mst_addr_out,
  output logic [DATA_W-1:0]     mst_data_out,
  input  logic                  mst_done_in,
  input  logic                  mst_nack_in,
  output logic                  busy_out,
  output logic                  nack_drop_out,
  output logic                  timeout_out,
  output logic [7:0]            drop_count_out
);

  // Reject inconsistent configurations at elaboration time.
  if (FIFO_WIDTH != ADDR_W + DATA_W || GAP_CYCLES < 1 || TIMEOUT_CYC < 2 || MAX_RETRY < 0)
  begin : g_bad_param
    $error("i2c_fifo_sched: inconsistent parameters");
  end

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            state_q;
  logic              rd_en_q;
  logic              start_q;
  logic              busy_q;
  logic              nack_drop_q;
  logic              timeout_q;
  logic [7:0]        drop_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [GAP_W-1:0]  gap_q;
  logic [WD_W-1:0]   wdog_q;

`ifdef I2C_RETRY_EN
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);

  logic [RT_W-1:0] retry_q;
  // Set when the running gap belongs to a retry: the gap then ends in ISSUE.
  logic            retry_pend_q;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i2c_clock_in) begin
    if (i2c_reset_in) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      nack_drop_q <= 1'b0;
      timeout_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
      addr_q      <= '0;
      data_q      <= '0;
      gap_q       <= '0;
      wdog_q      <= '0;
`ifdef I2C_RETRY_EN
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      // Strobes are high for exactly one cycle unless re-armed below.
      rd_en_q     <= 1'b0;
      start_q     <= 1'b0;
      nack_drop_q <= 1'b0;
      timeout_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (enable_in && !fifo_empty) begin
            state_q <= S_POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        S_POP: begin
          state_q <= S_LATCH;
        end

        // FIFO read data is valid now, one clock after the pop strobe.
        S_LATCH: begin
          addr_q  <= fifo_data_in[FIFO_WIDTH-1:DATA_W];
          data_q  <= fifo_data_in[DATA_W-1:0];
`ifdef I2C_RETRY_EN
          retry_q <= '0;
`endif
          state_q <= S_ISSUE;
          start_q <= 1'b1;
        end

        S_ISSUE: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end

        // Done is tested before the watchdog so a completion on the last
        // allowed clock still counts as a normal completion.
        S_WAIT: begin
          if (mst_done_in) begin
            gap_q   <= '0;
            state_q <= S_GAP;
            if (mst_nack_in) begin
`ifdef I2C_RETRY_EN
              if (retry_q < RT_MAX) begin
                retry_q      <= retry_q + 1'b1;
                retry_pend_q <= 1'b1;
              end else begin
                nack_drop_q <= 1'b1;
                drop_cnt_q  <= sat_inc(drop_cnt_q);
              end
`else
              nack_drop_q <= 1'b1;
              drop_cnt_q  <= sat_inc(drop_cnt_q);
`endif
            end
          end else if (wdog_q == WD_LAST) begin
            timeout_q  <= 1'b1;
            drop_cnt_q <= sat_inc(drop_cnt_q);
            gap_q      <= '0;
            state_q    <= S_GAP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
`ifdef I2C_RETRY_EN
            if (retry_pend_q) begin
              retry_pend_q <= 1'b0;
              state_q      <= S_ISSUE;
              start_q      <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en_out = rd_en_q;
  assign mst_start_out  = start_q;
  assign mst_addr_out   = addr_q;
  assign mst_data_out   = data_q;
  assign busy_out       = busy_q;
  assign nack_drop_out  = nack_drop_q;
  assign timeout_out    = timeout_q;
  assign drop_count_out = drop_cnt_q;

endmodule
